dpram_be: RTL and testbench
===========================

# dpram_be

Parametrised successor to the cipher's 16-byte dual-port state/round-key RAM. One synchronous write port with per-byte enables, one read port selectable as asynchronous (legacy) or registered, a defined read/write collision rule, and a hardware clear sequencer that zeroes the whole array after reset. Sits between the key-expansion engine (writer) and the round datapath (reader). Consumers must gate on `ready` before use.

## Interface
Parameters:
- `LOG2_L`, 4, log2 of word count; L = 2**LOG2_L words.
- `W_BYTES`, 16, bytes per word; word width = 8*W_BYTES.
- `RD_REG`, 1, 1 = registered read (latency 1); 0 = asynchronous read (latency 0).
- `WR_FIRST`, 1, collision rule for RD_REG=1: 1 = read returns new data, 0 = read returns old data.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `ready`  out  1  array cleared and ports live.
- `we`  in  1  write strobe.
- `wbe`  in  W_BYTES  byte enables; bit i gates byte i.
- `d_a`  in  LOG2_L  write address.
- `d`  in  W_BYTES x 8  write data, packed array of bytes, byte W_BYTES-1 most significant.
- `re`  in  1  read strobe.
- `q_a`  in  LOG2_L  read address.
- `q`  out  W_BYTES x 8  read data.
- `q_valid`  out  1  `q` carries data for an accepted read.

## Operation
- FSM states: RESET, CLEAR, READY.
- RESET: entered on any edge with `rst_n`=0 from any state. Clear counter := 0. `ready`, `q_valid` := 0; `q` := 0 (RD_REG=1).
- CLEAR: first edge with `rst_n`=1 leaves RESET for CLEAR. Each edge writes word `cnt` to all-zero, then cnt++. Entry at edge with cnt=L-1 is the last write, then go to READY. No wrap; counter is LOG2_L+1 bits or terminal-detected.
- READY: terminal state; leaves only on `rst_n`=0.
- `rst_n`=0 mid-CLEAR: abort, return to RESET, restart at 0 on release.
- In RESET/CLEAR: `we`, `re` ignored; no user write lands; `q_valid`=0.
- Write (READY, `we`=1): for each i with `wbe[i]`=1, mem[d_a].byte[i] := d.byte[i]; other bytes unchanged. `we`=1 with `wbe`=0 is a no-op.
- Read RD_REG=1: on edge with `re`=1 in READY, `q` := mem[q_a], `q_valid` := 1. `re`=0: `q` holds, `q_valid` := 0.
- Read RD_REG=0: `q` = mem[q_a] combinationally; `q_valid` = `re` & `ready`. `q` undefined-free (array zeroed) but not meaningful when `ready`=0.
- Collision (RD_REG=1, `we`&`re`, d_a==q_a): WR_FIRST=1 → `q` = byte-wise merge (enabled bytes from `d`, rest from old word); WR_FIRST=0 → `q` = old word.
- Collision RD_REG=0: `q` shows old word until the edge, new word after.

## Timing
- `rst_n` released before edge 0: CLEAR writes at edges 0..L-1; `ready`=1 after edge L-1 (L=16: first user write/read accepted at edge 16).
- `rst_n` asserted at edge k: `ready`=0 from k onward, regardless of state.
- Write latency: data visible to RD_REG=0 read after the writing edge; to RD_REG=1 read issued the next cycle (or same cycle per WR_FIRST).
- Read latency: RD_REG=1 → 1 cycle, one read per cycle, back-to-back sustained; RD_REG=0 → 0.
- Reset values: `ready`=0, `q_valid`=0, `q`=0.

## Structure
- Package `dpram_pkg`: `byte_t` (8-bit), `state_t` enum {RESET, CLEAR, READY}.
- Storage array and read path inline in `dpram_be`.
- Sub-module `dpram_clr_seq`: FSM plus clear counter; outputs clear-write address, clear-write strobe, `ready`.
- Write mux: clear path has priority over user port (user port blocked anyway when not READY).

## Test plan
- Reset release, L=16: `ready` 0 for 16 cycles, 1 at cycle 16; read all addresses → 128'h0, `q_valid` pulses.
- Byte-enable: write 0x0F..0x00 pattern to addr 3 full mask, then `wbe`=16'h0001 with d=all 0xAA → addr 3 reads …0x01,0xAA (only byte 0 changed).
- Collision RD_REG=1: addr 5 holds 0x11.., write 0x22.. mask 16'hFF00 with read addr 5 same cycle → WR_FIRST=1 gives upper 8 bytes 0x22, lower 0x11; WR_FIRST=0 gives all 0x11.
- Reset mid-clear: deassert, reassert at cycle 7, release → `ready` rises exactly 16 cycles after second release; words 0..6 still zero.
- Blocked access: `we`=1 to addr 2 with 0xFF.. during CLEAR → after `ready`, addr 2 reads 0; `q_valid` never 1 before `ready`.
- RD_REG=0: write addr 9 = 0x5A.., drive `q_a`=9 → `q` changes in the same cycle as the write edge, `q_valid` = `re`.

Source files
------------

// File: rtl/dpram_pkg.sv
// dpram_pkg: shared byte and sequencer-state types for the byte-enabled dual-port RAM
package dpram_pkg;
   typedef logic [7:0] byte_t;
   typedef enum logic [1:0] {RESET, CLEAR, READY} state_t;
endpackage

// File: rtl/dpram_clr_seq.sv
// dpram_clr_seq: post-reset sweep that zeroes every word before the ports go live
module dpram_clr_seq
   import dpram_pkg::*;
#(
   parameter int LOG2_L = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [LOG2_L-1:0] clr_a,
   output logic              clr_we,
   output logic              ready
);
   state_t            state, state_nx;
   logic [LOG2_L-1:0] cnt;
   // state register; counter advances per cleared word and parks on the last one
   always_ff @(posedge clk)
      if (!rst_n) begin
         state <= RESET;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         if (clr_we && state_nx != READY) cnt <= cnt + 1'b1;
      end
   // the RESET->CLEAR edge already writes word 0, so L edges clear L words
   always_comb begin
      state_nx = state;
      clr_we   = 1'b0;
      clr_a    = cnt;
      ready    = 1'b0;
      state_nx = (state == RESET) ? CLEAR : (state == CLEAR && &cnt) ? READY : state;
      clr_we   = rst_n && state != READY;
      ready    = state == READY;
   end
endmodule

// File: rtl/dpram_be.sv
// dpram_be: dual-port RAM with byte-enabled write, async or registered read, and hardware clear
module dpram_be
   import dpram_pkg::*;
#(
   parameter int LOG2_L   = 4,
   parameter int W_BYTES  = 16,
   parameter int RD_REG   = 1,
   parameter int WR_FIRST = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   output logic                       ready,
   input  logic                       we,
   input  logic [W_BYTES-1:0]         wbe,
   input  logic [LOG2_L-1:0]          d_a,
   input  byte_t [W_BYTES-1:0]        d,
   input  logic                       re,
   input  logic [LOG2_L-1:0]          q_a,
   output byte_t [W_BYTES-1:0]        q,
   output logic                       q_valid
);
   localparam int L = 2 ** LOG2_L;
   byte_t [W_BYTES-1:0] mem [L];
   byte_t [W_BYTES-1:0] merged;
   logic [LOG2_L-1:0]   clr_a;
   logic                clr_we;

   dpram_clr_seq #(.LOG2_L(LOG2_L)) u_clr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_a (clr_a),
      .clr_we(clr_we),
      .ready (ready)
   );

   // the addressed word as it will read after this edge's write
   always_comb begin
      merged = mem[d_a];
      for (int i = 0; i < W_BYTES; i++) merged[i] = wbe[i] ? d[i] : mem[d_a][i];
   end

   // clear sweep has priority; user writes land only once ready
   always_ff @(posedge clk)
      if (clr_we) mem[clr_a] <= '0;
      else if (we && ready) mem[d_a] <= merged;

   if (RD_REG != 0) begin : g_reg
      // registered read; same-address write is forwarded when WR_FIRST is set
      always_ff @(posedge clk)
         if (!rst_n) begin
            q       <= '0;
            q_valid <= 1'b0;
         end else begin
            q_valid <= re && ready;
            if (re && ready) q <= (WR_FIRST != 0 && we && d_a == q_a) ? merged : mem[q_a];
         end
   end else begin : g_async
      assign q       = mem[q_a];
      assign q_valid = re && ready;
   end
endmodule

// File: tb/tb_dpram_be.sv
// tb_dpram_be: randomized scoreboard bench for dpram_be in write-first, read-first and async-read builds
module tb_dpram_be;
   localparam int LG = 4, WB = 16, L = 16, DW = 128;
   typedef logic [DW-1:0] word_t;
   typedef struct {
      int    at;
      word_t data;
   } exp_t;

   logic clk = 1'b0, rst_n = 1'b0, we = 1'b0, re = 1'b0;
   logic [WB-1:0] wbe = '0;
   logic [LG-1:0] d_a = '0, q_a = '0;
   word_t d = '0;
   logic rdy_n, rdy_o, rdy_a, v_n, v_o, v_a;
   word_t q_n, q_o, q_as;

   word_t m_mem [L];
   bit    m_ready = 1'b0;
   int    m_cnt = 0;
   bit    last_rst = 1'b1;
   int    cyc_n = 0, n_vec = 0, n_bad = 0;
   exp_t  qa[$], qb[$];
   word_t hold_n = '0, hold_o = '0;

   dpram_be #(.LOG2_L(LG), .W_BYTES(WB), .RD_REG(1), .WR_FIRST(1)) u_new (
      .clk(clk), .rst_n(rst_n), .ready(rdy_n), .we(we), .wbe(wbe), .d_a(d_a), .d(d),
      .re(re), .q_a(q_a), .q(q_n), .q_valid(v_n));
   dpram_be #(.LOG2_L(LG), .W_BYTES(WB), .RD_REG(1), .WR_FIRST(0)) u_old (
      .clk(clk), .rst_n(rst_n), .ready(rdy_o), .we(we), .wbe(wbe), .d_a(d_a), .d(d),
      .re(re), .q_a(q_a), .q(q_o), .q_valid(v_o));
   dpram_be #(.LOG2_L(LG), .W_BYTES(WB), .RD_REG(0), .WR_FIRST(1)) u_async (
      .clk(clk), .rst_n(rst_n), .ready(rdy_a), .we(we), .wbe(wbe), .d_a(d_a), .d(d),
      .re(re), .q_a(q_a), .q(q_as), .q_valid(v_a));

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic chk(input string nm, input word_t act, input word_t exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc_n, act, exp);
      end
   endtask

   task automatic cyc();
      word_t mask, nw, old;
      exp_t  e;
      #1;
      chk("ready_wf", word_t'(rdy_n), word_t'(m_ready));
      chk("ready_rf", word_t'(rdy_o), word_t'(m_ready));
      chk("ready_async", word_t'(rdy_a), word_t'(m_ready));
      chk("qv_async", word_t'(v_a), word_t'(re && m_ready));
      if (m_ready) chk("q_async", q_as, m_mem[q_a]);
      if (!last_rst) begin
         chk("q_rst_wf", q_n, '0);
         chk("q_rst_rf", q_o, '0);
         chk("qv_rst", word_t'(v_n), '0);
      end
      for (int i = 0; i < WB; i++) mask[8*i +: 8] = {8{wbe[i]}};
      nw  = (d & mask) | (m_mem[d_a] & ~mask);
      old = m_mem[q_a];
      if (rst_n && m_ready && re) begin
         e.at   = cyc_n + 1;
         e.data = (we && d_a == q_a) ? nw : old;
         qa.push_back(e);
         e.data = old;
         qb.push_back(e);
      end
      @(posedge clk);
      if (!rst_n) begin
         m_ready = 1'b0;
         m_cnt   = 0;
      end else if (m_ready) begin
         if (we) m_mem[d_a] = nw;
      end else begin
         m_cnt++;
         if (m_cnt == L) begin
            m_ready = 1'b1;
            foreach (m_mem[i]) m_mem[i] = '0;
         end
      end
      last_rst = rst_n;
      @(negedge clk);
   endtask

   task automatic op(input bit w, input logic [WB-1:0] be, input int wa, input word_t wd,
                     input bit r, input int ra);
      we = w; wbe = be; d_a = LG'(wa); d = wd; re = r; q_a = LG'(ra);
      cyc();
   endtask

   // scoreboard monitor: each registered read must surface exactly one cycle after acceptance
   always @(negedge clk) begin
      exp_t e;
      if (!last_rst) begin
         hold_n = '0;
         hold_o = '0;
      end
      if (v_n) begin
         if (qa.size() == 0) chk("qv_spurious_wf", word_t'(v_n), '0);
         else begin
            e = qa.pop_front();
            chk("lat_wf", word_t'(cyc_n), word_t'(e.at));
            chk("q_wf", q_n, e.data);
            hold_n = e.data;
         end
      end else if (qa.size() != 0 && qa[0].at <= cyc_n) begin
         e = qa.pop_front();
         chk("qv_missing_wf", word_t'(v_n), 1);
      end else chk("q_hold_wf", q_n, hold_n);
      if (v_o) begin
         if (qb.size() == 0) chk("qv_spurious_rf", word_t'(v_o), '0);
         else begin
            e = qb.pop_front();
            chk("lat_rf", word_t'(cyc_n), word_t'(e.at));
            chk("q_rf", q_o, e.data);
            hold_o = e.data;
         end
      end else if (qb.size() != 0 && qb[0].at <= cyc_n) begin
         e = qb.pop_front();
         chk("qv_missing_rf", word_t'(v_o), 1);
      end else chk("q_hold_rf", q_o, hold_o);
   end

   initial begin
      @(negedge clk);
      repeat (3) cyc();
      rst_n = 1'b1;
      repeat (7) cyc();
      rst_n = 1'b0;
      repeat (2) cyc();
      rst_n = 1'b1;
      for (int i = 0; i < L; i++) op(1'b1, '1, 2, '1, 1'b1, i);
      for (int i = 0; i < L; i++) op(1'b0, '0, 0, '0, 1'b1, i);
      op(1'b1, '1, 3, 128'h0f0e0d0c0b0a09080706050403020100, 1'b0, 0);
      op(1'b1, 16'h0001, 3, {16{8'hAA}}, 1'b0, 0);
      op(1'b0, '0, 0, '0, 1'b1, 3);
      op(1'b1, '1, 5, {16{8'h11}}, 1'b0, 0);
      op(1'b1, 16'hFF00, 5, {16{8'h22}}, 1'b1, 5);
      op(1'b0, '0, 0, '0, 1'b1, 5);
      op(1'b1, '1, 9, {16{8'h5A}}, 1'b1, 9);
      op(1'b0, '0, 0, '0, 1'b1, 9);
      for (int n = 0; n < 1500; n++) begin
         rst_n = $urandom_range(0, 299) != 0;
         we    = rst_n && $urandom_range(0, 1) == 1;
         re    = rst_n && $urandom_range(0, 1) == 1;
         wbe   = WB'($urandom);
         d     = {$urandom, $urandom, $urandom, $urandom};
         d_a   = $urandom_range(0, 1) == 1 ? LG'($urandom_range(0, 3)) : LG'($urandom);
         q_a   = $urandom_range(0, 1) == 1 ? LG'($urandom_range(0, 3)) : LG'($urandom);
         cyc();
      end
      rst_n = 1'b1;
      we    = 1'b0;
      re    = 1'b0;
      repeat (20) cyc();
      chk("queue_drained", word_t'(qa.size() + qb.size()), '0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
